rv_cache_assoc: RTL
===================

// Module: rv_cache_assoc
// PURPOSE
//  Set-associative, write-through, no-write-allocate cache between a core port and a system slave.
//  Generalises the single-way, one-word-line cache: N ways, multi-word lines, burst refill FSM, round-robin victim.
//  Serves its ADDR_HI slave window only; other addresses bypass uncached.
// PARAMETERS
//  WAY_COUNT_BIT   1     log2 ways per set
//  LINE_SIZE_BIT   2     log2 32-bit words per line
//  SET_COUNT_BIT   3     log2 sets
//  ADDR_HI         4'b0  value of i_addr[31-:`SLAVE_SEL_WIDTH] selecting the cached window
//  Tag width TAG_W = 32 - `SLAVE_SEL_WIDTH - 2 - LINE_SIZE_BIT - SET_COUNT_BIT; tag = i_addr[27-:TAG_W].
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_reset_n      in   1   asynchronous active-low reset
//  i_addr         in   32  core byte address, held stable until o_ack
//  i_read         in   1   read request, held until o_ack
//  i_write        in   1   write request, held until o_ack
//  i_write_sel    in   4   byte enables for write
//  i_write_data   in   32  write data
//  i_flush        in   1   invalidate all lines (pulse)
//  o_data         out  32  read data, valid with o_ack
//  o_ack          out  1   request complete (1-cycle pulse)
//  o_miss         out  1   high while a request is being served by the bus
//  o_bus_addr     out  32  slave address (word aligned for refill)
//  o_bus_read     out  1   slave read strobe
//  o_bus_write    out  1   slave write strobe
//  o_bus_sel      out  4   slave byte enables
//  o_bus_wdata    out  32  slave write data
//  i_bus_data     in   32  slave read data
//  i_bus_ack      in   1   slave transfer complete
// BEHAVIOUR
//  Reset: all valid bits 0, victim pointers 0, FSM IDLE; o_ack, o_miss, o_bus_read, o_bus_write 0; o_data 0.
//  FSM states IDLE, REFILL, RESPOND, WRITE, BYPASS.
//  IDLE read hit (valid && tag match in any way, window selected): o_ack=1 same cycle, o_data=hit word, 0 wait states.
//  IDLE read miss in window -> REFILL: victim = lowest invalid way, else set's round-robin pointer.
//   Line invalidated on entry; word counter 0..LINE_SIZE-1, o_bus_addr = {line base, cnt, 2'b00}.
//   o_bus_read held high; each i_bus_ack writes i_bus_data to victim word cnt, cnt++.
//   On last beat: tag+valid written, pointer = victim+1 (mod WAY_COUNT) -> RESPOND.
//  RESPOND: o_ack=1, o_data = requested word from array -> IDLE. Miss latency = LINE_SIZE beats + 1.
//  IDLE write (any address in window) -> WRITE: o_bus_write=1, o_bus_addr=i_addr, sel/wdata passthrough.
//   On i_bus_ack: o_ack=1; if line hit, merge enabled bytes into cached word; miss does not allocate -> IDLE.
//  IDLE read or write outside window -> BYPASS: forward to bus, o_data=i_bus_data, o_ack=i_bus_ack, no array access.
//  i_read and i_write together: treated as write.
//  o_miss = 1 in REFILL, RESPOND, WRITE, BYPASS.
//  i_flush in IDLE: all valid bits cleared next edge, request in same cycle stalls one cycle.
//   i_flush elsewhere: latched as pending, applied on return to IDLE before next lookup.
//  i_flush during REFILL does not abort; the filled line is invalidated by the pending flush.
//  Async reset mid-REFILL: bus strobes drop immediately, partial line stays invalid.
//  Counter wrap: word counter LINE_SIZE_BIT wide, wraps to 0 after last beat; pointers wrap mod WAY_COUNT.
//  LINE_SIZE_BIT=0 and WAY_COUNT_BIT=0 legal (single-beat refill, direct-mapped).
// CONFIGURATION
//  RV_CACHE_STATS_EN defined: 32-bit r_counter_hit/r_counter_miss (reset 0, saturate at 2^32-1).
//   Hit increments on IDLE read-hit ack; miss increments on REFILL entry; exposed as o_hit_cnt/o_miss_cnt outputs.
//  Undefined: counters and their ports absent; all other behaviour identical.
// TESTING
//  Cold read 0x0000_0040 (LINE_SIZE_BIT=2) -> 4 bus reads 0x40..0x4C, o_ack one cycle after 4th ack, data = word 0x40.
//  Reread 0x0000_0048 -> o_ack same cycle, no bus strobe, data = beat 2.
//  Three lines mapping to same set, 2 ways -> third fill evicts way 0; reread of first line refills.
//  Write 0x0000_0044 sel=4'b0011 data=0xAAAA_BBBB on hit -> bus write, then read returns low half 0xBBBB merged.
//  Read 0x1000_0000 (outside ADDR_HI) -> single bus read, o_data=i_bus_data, second read also goes to bus.
//  i_flush pulsed mid-REFILL -> refill completes and acks, next read of same line misses.

Source files
------------

// File: rtl/rv_cache_assoc.sv
// Set-associative write-through, no-write-allocate cache with burst refill and round-robin victim.
// Optional hit/miss counters: define RV_CACHE_STATS_EN to add o_hit_cnt / o_miss_cnt.
`ifndef SLAVE_SEL_WIDTH
`define SLAVE_SEL_WIDTH 4
`endif

module rv_cache_assoc #(
  parameter int WAY_COUNT_BIT = 1,
  parameter int LINE_SIZE_BIT = 2,
  parameter int SET_COUNT_BIT = 3,
  parameter logic [`SLAVE_SEL_WIDTH-1:0] ADDR_HI = '0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [3:0]  i_write_sel,
  input  logic [31:0] i_write_data,
  input  logic        i_flush,
  output logic [31:0] o_data,
  output logic        o_ack,
  output logic        o_miss,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_read,
  output logic        o_bus_write,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_ack
`ifdef RV_CACHE_STATS_EN
  , output logic [31:0] o_hit_cnt
  , output logic [31:0] o_miss_cnt
`endif
);

  localparam int WAYS  = 1 << WAY_COUNT_BIT;
  localparam int LINE  = 1 << LINE_SIZE_BIT;
  localparam int SETS  = 1 << SET_COUNT_BIT;
  localparam int SEL_W = `SLAVE_SEL_WIDTH;
  localparam int TAG_W = 32 - SEL_W - 2 - LINE_SIZE_BIT - SET_COUNT_BIT;
  localparam int WAY_W = (WAY_COUNT_BIT > 0) ? WAY_COUNT_BIT : 1;
  localparam int CNT_W = (LINE_SIZE_BIT > 0) ? LINE_SIZE_BIT : 1;
  localparam int SET_W = (SET_COUNT_BIT > 0) ? SET_COUNT_BIT : 1;

  typedef enum logic [2:0] {S_IDLE, S_REFILL, S_RESPOND, S_WRITE, S_BYPASS} state_t;

  state_t            r_state, w_next;
  logic              r_valid [WAYS][SETS];
  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [31:0]       r_data  [WAYS][SETS][LINE];
  logic [WAY_W-1:0]  r_ptr   [SETS];
  logic [CNT_W-1:0]  r_cnt;
  logic [WAY_W-1:0]  r_victim;
  logic              r_flush_pend;

  logic              w_in_win, w_hit, w_last;
  logic [TAG_W-1:0]  w_tag;
  logic [SET_W-1:0]  w_set;
  logic [CNT_W-1:0]  w_word;
  logic [WAY_W-1:0]  w_hit_way, w_victim;
  logic [31:0]       w_refill_addr;
  logic              w_flush_now, w_refill_start, w_fill_beat, w_merge, w_hit_ack;

  assign w_in_win      = (i_addr[31 -: SEL_W] == ADDR_HI);
  assign w_tag         = i_addr[31-SEL_W -: TAG_W];
  assign w_set         = SET_W'((i_addr >> (2 + LINE_SIZE_BIT)) & 32'(SETS - 1));
  assign w_word        = CNT_W'((i_addr >> 2) & 32'(LINE - 1));
  assign w_last        = (r_cnt == CNT_W'(LINE - 1));
  assign w_refill_addr = (i_addr & ~32'(LINE * 4 - 1)) | (32'(r_cnt) << 2);

  // Lowest matching way wins; victim prefers the lowest invalid way over the pointer.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = r_ptr[w_set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_set] && (r_tag[w][w_set] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w][w_set]) w_victim = WAY_W'(w);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    o_ack          = 1'b0;
    o_miss         = 1'b0;
    o_data         = '0;
    o_bus_addr     = i_addr;
    o_bus_read     = 1'b0;
    o_bus_write    = 1'b0;
    o_bus_sel      = i_write_sel;
    o_bus_wdata    = i_write_data;
    w_flush_now    = 1'b0;
    w_refill_start = 1'b0;
    w_fill_beat    = 1'b0;
    w_merge        = 1'b0;
    w_hit_ack      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_flush || r_flush_pend) begin
          w_flush_now = 1'b1;
        end else if (i_write) begin
          w_next = w_in_win ? S_WRITE : S_BYPASS;
        end else if (i_read) begin
          if (!w_in_win) begin
            w_next = S_BYPASS;
          end else if (w_hit) begin
            o_ack     = 1'b1;
            o_data    = r_data[w_hit_way][w_set][w_word];
            w_hit_ack = 1'b1;
          end else begin
            w_refill_start = 1'b1;
            w_next         = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        o_miss     = 1'b1;
        o_bus_read = 1'b1;
        o_bus_addr = w_refill_addr;
        o_bus_sel  = 4'hF;
        if (i_bus_ack) begin
          w_fill_beat = 1'b1;
          if (w_last) w_next = S_RESPOND;
        end
      end
      S_RESPOND: begin
        o_miss = 1'b1;
        o_ack  = 1'b1;
        o_data = r_data[r_victim][w_set][w_word];
        w_next = S_IDLE;
      end
      S_WRITE: begin
        o_miss      = 1'b1;
        o_bus_write = 1'b1;
        if (i_bus_ack) begin
          o_ack   = 1'b1;
          w_merge = w_hit;
          w_next  = S_IDLE;
        end
      end
      S_BYPASS: begin
        o_miss      = 1'b1;
        o_bus_write = i_write;
        o_bus_read  = !i_write;
        o_bus_sel   = i_write ? i_write_sel : 4'hF;
        o_data      = i_bus_data;
        o_ack       = i_bus_ack;
        if (i_bus_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt        <= '0;
      r_victim     <= '0;
      r_flush_pend <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
      end
    end else begin
      if (w_flush_now)                         r_flush_pend <= 1'b0;
      else if (i_flush && r_state != S_IDLE)   r_flush_pend <= 1'b1;

      if (w_flush_now) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
      end
      if (w_refill_start) begin
        r_cnt                    <= '0;
        r_victim                 <= w_victim;
        r_valid[w_victim][w_set] <= 1'b0;
      end
      if (w_fill_beat) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_valid[r_victim][w_set] <= 1'b1;
          r_ptr[w_set] <= (r_victim == WAY_W'(WAYS - 1)) ? '0 : r_victim + 1'b1;
        end
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge i_clk) begin
    if (w_fill_beat) begin
      r_data[r_victim][w_set][r_cnt] <= i_bus_data;
      if (w_last) r_tag[r_victim][w_set] <= w_tag;
    end
    if (w_merge) begin
      for (int b = 0; b < 4; b++)
        if (i_write_sel[b])
          r_data[w_hit_way][w_set][w_word][b*8 +: 8] <= i_write_data[b*8 +: 8];
    end
  end

`ifdef RV_CACHE_STATS_EN
  logic [31:0] r_counter_hit, r_counter_miss;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_counter_hit  <= '0;
      r_counter_miss <= '0;
    end else begin
      if (w_hit_ack && (r_counter_hit != '1))       r_counter_hit  <= r_counter_hit + 1'b1;
      if (w_refill_start && (r_counter_miss != '1)) r_counter_miss <= r_counter_miss + 1'b1;
    end
  end

  assign o_hit_cnt  = r_counter_hit;
  assign o_miss_cnt = r_counter_miss;
`endif

endmodule
